// File: rtl/unidade_controle_jogo_param_pkg.sv
// Shared definitions for the parametrised sequence-memory game control unit:
// 4-bit state codes (D = fim_timeout, F = debug code for an invalid state),
// play-mode encoding, the registered output bundle and its Moore decoder.
package unidade_controle_jogo_param_pkg;

  typedef enum logic [3:0] {
    ST_INICIAL     = 4'h0,
    ST_PREPARACAO  = 4'h1,
    ST_NOVA_SEQ    = 4'h2,
    ST_ESPERA      = 4'h3,
    ST_REGISTRA    = 4'h4,
    ST_COMPARACAO  = 4'h5,
    ST_PROXIMO     = 4'h6,
    ST_PERDE_VIDA  = 4'h7,
    ST_FIM_ACERTO  = 4'hA,
    ST_FIM_TIMEOUT = 4'hD,
    ST_FIM_ERRO    = 4'hE
  } estado_t;

  localparam logic [3:0] DB_INVALIDO = 4'hF;

  localparam logic MODO_PROGRESSIVO = 1'b0;
  localparam logic MODO_COMPLETO    = 1'b1;

  typedef struct packed {
    logic       zeraE;
    logic       contaE;
    logic       zeraL;
    logic       contaL;
    logic       zeraR;
    logic       registraR;
    logic       ganhou;
    logic       perdeu;
    logic       pronto;
    logic       deu_timeout;
    logic [3:0] db_estado;
  } saida_t;

  // Moore output decode for one state; unknown codes behave as inicial but report F.
  function automatic saida_t decodifica_saidas(input estado_t e);
    saida_t s;
    s           = '0;
    s.db_estado = 4'(e);
    case (e)
      ST_INICIAL:     begin s.zeraE = 1'b1; s.zeraR  = 1'b1; end
      ST_PREPARACAO:  begin s.zeraE = 1'b1; s.zeraL  = 1'b1; end
      ST_NOVA_SEQ:    begin s.zeraE = 1'b1; s.contaL = 1'b1; end
      ST_REGISTRA:    s.registraR = 1'b1;
      ST_PROXIMO:     s.contaE    = 1'b1;
      ST_PERDE_VIDA:  s.zeraE     = 1'b1;
      ST_FIM_ACERTO:  begin s.ganhou = 1'b1; s.pronto = 1'b1; end
      ST_FIM_TIMEOUT: begin s.perdeu = 1'b1; s.pronto = 1'b1; s.deu_timeout = 1'b1; end
      ST_FIM_ERRO:    begin s.perdeu = 1'b1; s.pronto = 1'b1; end
      ST_ESPERA, ST_COMPARACAO: ;
      default: begin
        s.zeraE     = 1'b1;
        s.zeraR     = 1'b1;
        s.db_estado = DB_INVALIDO;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/unidade_controle_jogo_param_if.sv
// Bus between the game wrapper/datapath and the control unit.
// master: wrapper/datapath side (drives requests and datapath flags).
// slave : control unit (drives datapath controls, result flags, vidas, db_estado).
interface unidade_controle_jogo_param_if #(
  parameter int unsigned LIVES_W = 4
);
  logic               jogar;
  logic               jogada;
  logic               modo;
  logic               igualE;
  logic               igualL;
  logic               fimE;
  logic               fimL;
  logic               zeraE;
  logic               contaE;
  logic               zeraL;
  logic               contaL;
  logic               zeraR;
  logic               registraR;
  logic               ganhou;
  logic               perdeu;
  logic               pronto;
  logic               deu_timeout;
  logic [LIVES_W-1:0] vidas;
  logic [3:0]         db_estado;

  modport master (
    output jogar, jogada, modo, igualE, igualL, fimE, fimL,
    input  zeraE, contaE, zeraL, contaL, zeraR, registraR,
    input  ganhou, perdeu, pronto, deu_timeout, vidas, db_estado
  );

  modport slave (
    input  jogar, jogada, modo, igualE, igualL, fimE, fimL,
    output zeraE, contaE, zeraL, contaL, zeraR, registraR,
    output ganhou, perdeu, pronto, deu_timeout, vidas, db_estado
  );
endinterface

// File: rtl/unidade_controle_jogo_param_contador_timeout.sv
// Response-timeout counter: cleared by zera, advances on conta, and flags fim
// once TIMEOUT_CYCLES-1 has been reached (holding there until cleared).
// Ports: clock, reset (sync, active-high), zera, conta -> fim.
module contador_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign fim = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Saturates at the terminal value so fim cannot be missed by wrapping.
  always_ff @(posedge clock) begin
    if (reset || zera) begin
      r_cnt <= '0;
    end else if (conta && !fim) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/unidade_controle_jogo_param.sv
// Moore control unit for the sequence-memory game with lives, optional
// response timeout and progressive/full-sequence play modes.
// Ports: clock, reset (sync, active-high), bus (slave modport): requests
// jogar/jogada/modo, datapath flags igualE/igualL/fimE/fimL, datapath
// controls, result flags, vidas and db_estado.
// Build option: define UCJ_TIMEOUT_EN to include the espera timeout counter;
// without it espera waits indefinitely and deu_timeout stays 0.
module unidade_controle_jogo_param
  import unidade_controle_jogo_param_pkg::*;
#(
  parameter int unsigned NUM_LIVES      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned LIVES_W        = 4
) (
  input logic                          clock,
  input logic                          reset,
  unidade_controle_jogo_param_if.slave bus
);

  estado_t            r_estado;
  estado_t            w_proximo;
  saida_t             r_saida;
  saida_t             w_saida;
  logic [LIVES_W-1:0] r_vidas;
  logic               r_modo;
  logic               w_timeout;
  logic               w_ha_vidas;
  logic               w_entra_perda;
  logic               w_unused;

  // fimL is a debug-only datapath flag.
  assign w_unused = bus.fimL;

  assign w_ha_vidas    = (r_vidas > LIVES_W'(1));
  assign w_entra_perda = (w_proximo != r_estado) &&
                         (w_proximo inside {ST_PERDE_VIDA, ST_FIM_ERRO, ST_FIM_TIMEOUT});

`ifdef UCJ_TIMEOUT_EN
  logic w_fim_timer;
  logic w_zera_timer;
  logic w_conta_timer;

  // Timer runs only in espera, so every fresh entry starts from zero.
  assign w_conta_timer = (r_estado == ST_ESPERA);
  assign w_zera_timer  = !w_conta_timer;

  contador_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_contador_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (w_zera_timer),
    .conta (w_conta_timer),
    .fim   (w_fim_timer)
  );

  assign w_timeout = w_fim_timer && (r_estado == ST_ESPERA);
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_estado <= ST_INICIAL;
    else       r_estado <= w_proximo;
  end

  // Next-state logic
  always_comb begin
    w_proximo = r_estado;
    case (r_estado)
      ST_INICIAL:    if (bus.jogar) w_proximo = ST_PREPARACAO;
      ST_PREPARACAO: w_proximo = ST_ESPERA;
      ST_NOVA_SEQ:   w_proximo = ST_ESPERA;
      ST_ESPERA: begin
        // Timeout takes priority over a jogada in the same cycle.
        if (w_timeout)       w_proximo = w_ha_vidas ? ST_PERDE_VIDA : ST_FIM_TIMEOUT;
        else if (bus.jogada) w_proximo = ST_REGISTRA;
      end
      ST_REGISTRA:   w_proximo = ST_COMPARACAO;
      ST_COMPARACAO: begin
        if (!bus.igualE)                                    w_proximo = w_ha_vidas ? ST_PERDE_VIDA : ST_FIM_ERRO;
        else if (bus.fimE)                                  w_proximo = ST_FIM_ACERTO;
        else if ((r_modo == MODO_PROGRESSIVO) && bus.igualL) w_proximo = ST_NOVA_SEQ;
        else                                                w_proximo = ST_PROXIMO;
      end
      ST_PROXIMO:    w_proximo = ST_ESPERA;
      ST_PERDE_VIDA: w_proximo = ST_ESPERA;
      ST_FIM_ACERTO, ST_FIM_TIMEOUT, ST_FIM_ERRO:
        if (bus.jogar) w_proximo = ST_PREPARACAO;
      default:       w_proximo = ST_INICIAL;
    endcase
  end

  // Output decode of the upcoming state, so the registered outputs track r_estado.
  always_comb begin
    w_saida = decodifica_saidas(w_proximo);
`ifndef UCJ_TIMEOUT_EN
    w_saida.deu_timeout = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) r_saida <= decodifica_saidas(ST_INICIAL);
    else       r_saida <= w_saida;
  end

  // Lives: loaded entering preparacao, one taken on entry to any loss state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vidas <= '0;
    end else if (w_proximo == ST_PREPARACAO) begin
      r_vidas <= LIVES_W'(NUM_LIVES);
    end else if (w_entra_perda && (r_vidas != '0)) begin
      r_vidas <= r_vidas - LIVES_W'(1);
    end
  end

  // Play mode is latched once per game.
  always_ff @(posedge clock) begin
    if (reset)                           r_modo <= MODO_PROGRESSIVO;
    else if (r_estado == ST_PREPARACAO) r_modo <= bus.modo;
  end

  assign bus.zeraE       = r_saida.zeraE;
  assign bus.contaE      = r_saida.contaE;
  assign bus.zeraL       = r_saida.zeraL;
  assign bus.contaL      = r_saida.contaL;
  assign bus.zeraR       = r_saida.zeraR;
  assign bus.registraR   = r_saida.registraR;
  assign bus.ganhou      = r_saida.ganhou;
  assign bus.perdeu      = r_saida.perdeu;
  assign bus.pronto      = r_saida.pronto;
  assign bus.deu_timeout = r_saida.deu_timeout;
  assign bus.db_estado   = r_saida.db_estado;
  assign bus.vidas       = r_vidas;

endmodule

// File: tb/tb_unidade_controle_jogo_param.sv
// Directed bench for unidade_controle_jogo_param (NUM_LIVES=3, TIMEOUT_CYCLES=8).
// Observed vector: {db_estado, vidas, zeraE contaE zeraL contaL zeraR registraR
// ganhou perdeu pronto deu_timeout}.
module tb_unidade_controle_jogo_param;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  unidade_controle_jogo_param_if #(.LIVES_W(4)) bus ();

  unidade_controle_jogo_param #(
    .NUM_LIVES      (3),
    .TIMEOUT_CYCLES (8),
    .LIVES_W        (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Expected flag patterns per state
  localparam logic [9:0] F_INI  = 10'b1000100000;
  localparam logic [9:0] F_PREP = 10'b1010000000;
  localparam logic [9:0] F_NOVA = 10'b1001000000;
  localparam logic [9:0] F_ESP  = 10'b0000000000;
  localparam logic [9:0] F_REG  = 10'b0000010000;
  localparam logic [9:0] F_CMP  = 10'b0000000000;
  localparam logic [9:0] F_PROX = 10'b0100000000;
  localparam logic [9:0] F_PERD = 10'b1000000000;
  localparam logic [9:0] F_ACE  = 10'b0000001010;
  localparam logic [9:0] F_TO   = 10'b0000000111;
  localparam logic [9:0] F_ERR  = 10'b0000000110;

  function automatic logic [17:0] obs();
    return {bus.db_estado, bus.vidas, bus.zeraE, bus.contaE, bus.zeraL, bus.contaL,
            bus.zeraR, bus.registraR, bus.ganhou, bus.perdeu, bus.pronto, bus.deu_timeout};
  endfunction

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // From espera: key press, then comparacao with the given datapath flags; ends one edge after comparacao.
  task automatic play(input logic ig_e, input logic ig_l, input logic fe);
    bus.jogada = 1'b1;
    step();
    bus.jogada = 1'b0;
    bus.igualE = ig_e;
    bus.igualL = ig_l;
    bus.fimE   = fe;
    step();
    step();
    bus.igualE = 1'b0;
    bus.igualL = 1'b0;
    bus.fimE   = 1'b0;
  endtask

  task automatic start_game(input logic m);
    bus.modo  = m;
    bus.jogar = 1'b1;
    step();
    bus.jogar = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [17:0] e;
    reset = 1'b1;
    bus.jogar = 1'b0; bus.jogada = 1'b0; bus.modo = 1'b0;
    bus.igualE = 1'b0; bus.igualL = 1'b0; bus.fimE = 1'b0; bus.fimL = 1'b0;
    step(); step();
    e = {4'h0, 4'd0, F_INI}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_inicial got %h expected %h", obs(), e); end
    reset = 1'b0;
    step();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL idle_inicial got %h expected %h", obs(), e); end
    bus.jogada = 1'b1; step(); bus.jogada = 1'b0;
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL jogada_in_inicial got %h expected %h", obs(), e); end
  endtask

  task automatic test_start();
    logic [17:0] e;
    bus.modo = 1'b0; bus.jogar = 1'b1; step(); bus.jogar = 1'b0;
    e = {4'h1, 4'd3, F_PREP}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL start_prep got %h expected %h", obs(), e); end
    step();
    e = {4'h3, 4'd3, F_ESP}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL start_espera got %h expected %h", obs(), e); end
    bus.jogar = 1'b1; step(); bus.jogar = 1'b0;
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL jogar_in_espera got %h expected %h", obs(), e); end
  endtask

  task automatic test_progressive_win();
    logic [17:0] e;
    bus.jogada = 1'b1; step(); bus.jogada = 1'b0;
    e = {4'h4, 4'd3, F_REG}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL win_registra got %h expected %h", obs(), e); end
    bus.igualE = 1'b1; bus.igualL = 1'b1; bus.fimE = 1'b0;
    step();
    e = {4'h5, 4'd3, F_CMP}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL win_comparacao got %h expected %h", obs(), e); end
    step();
    bus.igualE = 1'b0; bus.igualL = 1'b0;
    e = {4'h2, 4'd3, F_NOVA}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL win_nova_seq got %h expected %h", obs(), e); end
    step();
    play(1'b1, 1'b0, 1'b0);
    e = {4'h6, 4'd3, F_PROX}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL win_proximo got %h expected %h", obs(), e); end
    step();
    play(1'b1, 1'b1, 1'b1);
    e = {4'hA, 4'd3, F_ACE}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL win_fim_acerto got %h expected %h", obs(), e); end
    step();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL win_hold got %h expected %h", obs(), e); end
  endtask

  task automatic test_miss_lives();
    logic [17:0] e;
    start_game(1'b0);
    e = {4'h3, 4'd3, F_ESP}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL miss_restart got %h expected %h", obs(), e); end
    play(1'b0, 1'b0, 1'b0);
    e = {4'h7, 4'd2, F_PERD}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL miss1_perde_vida got %h expected %h", obs(), e); end
    step();
    e = {4'h3, 4'd2, F_ESP}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL miss1_espera got %h expected %h", obs(), e); end
    play(1'b0, 1'b0, 1'b0);
    e = {4'h7, 4'd1, F_PERD}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL miss2_perde_vida got %h expected %h", obs(), e); end
    step();
    play(1'b0, 1'b0, 1'b0);
    e = {4'hE, 4'd0, F_ERR}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL miss3_fim_erro got %h expected %h", obs(), e); end
    bus.jogada = 1'b1; step(); bus.jogada = 1'b0;
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL fim_erro_hold got %h expected %h", obs(), e); end
  endtask

  task automatic test_modo_completo();
    logic [17:0] e;
    bus.modo = 1'b1; bus.jogar = 1'b1; step(); bus.jogar = 1'b0;
    e = {4'h1, 4'd3, F_PREP}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL completo_prep got %h expected %h", obs(), e); end
    step();
    bus.modo = 1'b0;
    play(1'b1, 1'b1, 1'b0);
    e = {4'h6, 4'd3, F_PROX}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL completo_igualL_ignored got %h expected %h", obs(), e); end
    step();
    play(1'b1, 1'b0, 1'b1);
    e = {4'hA, 4'd3, F_ACE}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL completo_fim_acerto got %h expected %h", obs(), e); end
  endtask

  task automatic test_reset_mid();
    logic [17:0] e;
    start_game(1'b0);
    bus.jogada = 1'b1; step(); bus.jogada = 1'b0;
    step();
    e = {4'h5, 4'd3, F_CMP}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL resetmid_comparacao got %h expected %h", obs(), e); end
    reset = 1'b1;
    step();
    e = {4'h0, 4'd0, F_INI}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL resetmid_inicial got %h expected %h", obs(), e); end
    bus.jogar = 1'b1; step();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_held_jogar got %h expected %h", obs(), e); end
    bus.jogar = 1'b0; reset = 1'b0;
    step();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_release got %h expected %h", obs(), e); end
  endtask

`ifdef UCJ_TIMEOUT_EN
  task automatic test_timeout();
    logic [17:0] e;
    start_game(1'b0);
    repeat (7) step();
    e = {4'h3, 4'd3, F_ESP}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL timeout_before_limit got %h expected %h", obs(), e); end
    step();
    e = {4'h7, 4'd2, F_PERD}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL timeout_perde_vida got %h expected %h", obs(), e); end
    step();
    repeat (5) step();
    play(1'b1, 1'b0, 1'b0);
    step();
    repeat (7) step();
    e = {4'h3, 4'd2, F_ESP}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL timer_cleared got %h expected %h", obs(), e); end
    step();
    e = {4'h7, 4'd1, F_PERD}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL timeout2_perde_vida got %h expected %h", obs(), e); end
    step();
    repeat (7) step();
    bus.jogada = 1'b1; step(); bus.jogada = 1'b0;
    e = {4'hD, 4'd0, F_TO}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL timeout_fim got %h expected %h", obs(), e); end
  endtask
`else
  task automatic test_no_timeout();
    logic [17:0] e;
    start_game(1'b0);
    repeat (10000) step();
    e = {4'h3, 4'd3, F_ESP}; checks++;
    if (obs() !== e) begin errors++; $display("FAIL no_timeout_espera got %h expected %h", obs(), e); end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_progressive_win();
    test_miss_lives();
    test_modo_completo();
    test_reset_mid();
`ifdef UCJ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
